sccomp_trace_harness: RTL and testbench

- Synthesizable run-control and trace harness for the single-cycle CPU top.
- Holds the CPU in reset for a programmable number of cycles, then releases it and runs it for a bounded time or until a stop PC.
- Records a PC/instruction history in a circular buffer, then freezes the CPU and scans its register file through the reg_sel/reg_data debug port.
- Sits beside the CPU in both simulation and FPGA builds and replaces hand-timed bench stimulus.

---
 rtl/sccomp_trace_harness.sv | 122 ++++++++++++
 tb/tb_sccomp_trace_harness.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sccomp_trace_harness.sv
// sccomp_trace_harness: run-control, PC/instruction trace and register dump harness for the single-cycle CPU
module sccomp_trace_harness #(
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 10,
  parameter int NREGS      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop_en,
  input  logic [PC_W-1:0]            stop_pc,
  input  logic [PC_W-1:0]            cpu_pc,
  input  logic [INSTR_W-1:0]         cpu_instr,
  output logic                       cpu_rstn,
  output logic                       cpu_run,
  output logic [4:0]                 reg_sel,
  input  logic [DATA_W-1:0]          reg_data,
  output logic                       dump_valid,
  output logic [4:0]                 dump_idx,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       busy,
  output logic                       done,
  output logic                       hit,
  output logic [$clog2(DEPTH):0]     trace_cnt,
  output logic                       trace_wrap,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [PC_W+INSTR_W-1:0]    rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int EW = PC_W + INSTR_W;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DUMP, DONE} state_t;
  state_t state, nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, ridx;
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic go, stop_hit, hold_last, run_last, dump_last;
  assign go        = start && (state == IDLE || state == DONE);
  assign stop_hit  = stop_en && cpu_pc == stop_pc;
  assign hold_last = hcnt == HW'(RST_CYCLES - 1);
  assign run_last  = rcnt == RW'(RUN_CYCLES - 1);
  assign dump_last = reg_sel == 5'(NREGS - 1);
  assign ridx      = (trace_wrap ? wptr : '0) + rd_addr;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  // next-state: a capture always happens in the RUN cycle that decides to exit
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? HOLD : state;
      HOLD:       nxt = hold_last ? RUN : HOLD;
      RUN:        nxt = (stop_hit || run_last) ? DUMP : RUN;
      DUMP:       nxt = dump_last ? DONE : DUMP;
      default:    nxt = IDLE;
    endcase
  end
  // CPU control and status decoded from state
  always_comb begin
    cpu_rstn = state == RUN || state == DUMP || state == DONE;
    cpu_run  = state == RUN;
    busy     = state == HOLD || state == RUN || state == DUMP;
    done     = state == DONE;
  end
  // counters, trace bookkeeping and the register dump pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      rcnt       <= '0;
      wptr       <= '0;
      trace_cnt  <= '0;
      trace_wrap <= 1'b0;
      hit        <= 1'b0;
      reg_sel    <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      dump_valid <= state == DUMP;
      if (go) begin
        hcnt       <= '0;
        rcnt       <= '0;
        wptr       <= '0;
        trace_cnt  <= '0;
        trace_wrap <= 1'b0;
        hit        <= 1'b0;
        reg_sel    <= '0;
      end
      if (state == HOLD) hcnt <= hcnt + HW'(1);
      if (state == RUN) begin
        wptr       <= wptr + AW'(1);
        rcnt       <= rcnt + RW'(1);
        trace_cnt  <= trace_cnt == FULL ? trace_cnt : trace_cnt + (AW + 1)'(1);
        trace_wrap <= trace_wrap || trace_cnt == FULL;
        if (stop_hit) hit <= 1'b1;
      end
      if (state == DUMP) begin
        dump_idx  <= reg_sel;
        dump_data <= reg_data;
        reg_sel   <= dump_last ? '0 : reg_sel + 5'd1;
      end
    end
  end
  // trace storage, written once per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst && state == RUN) mem[wptr] <= {cpu_pc, cpu_instr};
  end
  // registered readout relative to the oldest entry; no bypass of the same-cycle write
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= ({1'b0, rd_addr} < trace_cnt) ? mem[ridx] : '0;
  end
endmodule

// File: tb/tb_sccomp_trace_harness.sv
// tb_sccomp_trace_harness: scoreboard bench for sccomp_trace_harness with a simple CPU model per instance
module tb_sccomp_trace_harness;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start_a, start_b, stop_en;
  logic [31:0] stop_pc;
  logic [3:0] rd_addr;
  logic rstn_a, run_a, dv_a, busy_a, done_a, hit_a, wrap_a;
  logic rstn_b, run_b, dv_b, busy_b, done_b, hit_b, wrap_b;
  logic [4:0] sel_a, idx_a, cnt_a, sel_b, idx_b, cnt_b;
  logic [31:0] dd_a, dd_b, pc_a, pc_b, instr_a, instr_b, regd_a, regd_b;
  logic [63:0] rd_a, rd_b;
  int pass_n = 0, tot_n = 0;
  logic [36:0] q_a[$], q_b[$];
  logic prev_a = 1'b0, prev_b = 1'b0;

  sccomp_trace_harness #(.DEPTH(16), .RST_CYCLES(2), .RUN_CYCLES(10), .NREGS(32)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stop_en(stop_en), .stop_pc(stop_pc),
    .cpu_pc(pc_a), .cpu_instr(instr_a), .cpu_rstn(rstn_a), .cpu_run(run_a),
    .reg_sel(sel_a), .reg_data(regd_a), .dump_valid(dv_a), .dump_idx(idx_a),
    .dump_data(dd_a), .busy(busy_a), .done(done_a), .hit(hit_a),
    .trace_cnt(cnt_a), .trace_wrap(wrap_a), .rd_addr(rd_addr), .rd_data(rd_a));

  sccomp_trace_harness #(.DEPTH(16), .RST_CYCLES(2), .RUN_CYCLES(20), .NREGS(32)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop_en(stop_en), .stop_pc(stop_pc),
    .cpu_pc(pc_b), .cpu_instr(instr_b), .cpu_rstn(rstn_b), .cpu_run(run_b),
    .reg_sel(sel_b), .reg_data(regd_b), .dump_valid(dv_b), .dump_idx(idx_b),
    .dump_data(dd_b), .busy(busy_b), .done(done_b), .hit(hit_b),
    .trace_cnt(cnt_b), .trace_wrap(wrap_b), .rd_addr(rd_addr), .rd_data(rd_b));

  // CPU models: PC steps by 4 while enabled, clears in reset
  always @(posedge clk) begin
    pc_a <= !rstn_a ? 32'h0 : run_a ? pc_a + 32'd4 : pc_a;
    pc_b <= !rstn_b ? 32'h0 : run_b ? pc_b + 32'd4 : pc_b;
  end
  assign instr_a = pc_a | 32'hA000_0000;
  assign instr_b = pc_b | 32'hA000_0000;
  assign regd_a  = 32'(sel_a) * 32'd3;
  assign regd_b  = 32'(sel_b) * 32'd3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_dump(input bit b);
    for (int i = 0; i < 32; i++)
      if (b) q_b.push_back({5'(i), 32'(i * 3)});
      else   q_a.push_back({5'(i), 32'(i * 3)});
  endtask

  task automatic pulse(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b);
    for (int n = 0; n < 300 && !(b ? done_b : done_a); n++) @(negedge clk);
    chk(b ? "done_b_seen" : "done_a_seen", b ? done_b : done_a, 1);
  endtask

  task automatic rd(input bit b, input logic [3:0] a, input logic [63:0] exp, input string nm);
    rd_addr = a;
    @(negedge clk);
    chk(nm, b ? rd_b : rd_a, exp);
  endtask

  // dump monitors: pop the expected {idx,data} whenever the DUT presents a dump beat
  always @(negedge clk) begin
    logic [36:0] e;
    if (dv_a) begin
      if (q_a.size() == 0) begin
        tot_n++;
        $display("FAIL dump_a_extra: got idx %0d expected no beat", idx_a);
      end else begin
        e = q_a.pop_front();
        chk("dump_a", {idx_a, dd_a}, e);
      end
      chk("dump_a_run", run_a, 0);
      if (idx_a != 0) chk("dump_a_contig", prev_a, 1);
      chk("dump_a_done", done_a, idx_a == 5'd31);
    end
    prev_a = dv_a;
    if (dv_b) begin
      if (q_b.size() == 0) begin
        tot_n++;
        $display("FAIL dump_b_extra: got idx %0d expected no beat", idx_b);
      end else begin
        e = q_b.pop_front();
        chk("dump_b", {idx_b, dd_b}, e);
      end
      chk("dump_b_run", run_b, 0);
      if (idx_b != 0) chk("dump_b_contig", prev_b, 1);
      chk("dump_b_done", done_b, idx_b == 5'd31);
    end
    prev_b = dv_b;
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stop_en = 1'b0; stop_pc = 32'h0; rd_addr = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_rstn", rstn_a, 0);
    chk("rst_run", run_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_hit", hit_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_dv", dv_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_rd", rd_a, 0);
    rst = 1'b0;
    @(negedge clk);
    // reset hold and run limit
    push_dump(0);
    pulse(0);
    chk("hold_busy", busy_a, 1);
    chk("hold1_rstn", rstn_a, 0);
    @(negedge clk);
    chk("hold2_rstn", rstn_a, 0);
    @(negedge clk);
    chk("run_rstn", rstn_a, 1);
    chk("run_run", run_a, 1);
    wait_done(0);
    chk("lim_cnt", cnt_a, 10);
    chk("lim_wrap", wrap_a, 0);
    chk("lim_hit", hit_a, 0);
    rd(0, 4'd0, {32'h0, 32'hA000_0000}, "lim_rd0");
    rd(0, 4'd9, {32'h24, 32'hA000_0024}, "lim_rd9");
    rd(0, 4'd12, 64'h0, "lim_rd12");
    // wrap
    push_dump(1);
    pulse(1);
    wait_done(1);
    chk("wrap_cnt", cnt_b, 16);
    chk("wrap_wrap", wrap_b, 1);
    chk("wrap_hit", hit_b, 0);
    rd(1, 4'd0, {32'h10, 32'hA000_0010}, "wrap_rd0");
    rd(1, 4'd15, {32'h4C, 32'hA000_004C}, "wrap_rd15");
    // stop PC, restarted from DONE
    stop_en = 1'b1; stop_pc = 32'h1C;
    push_dump(1);
    pulse(1);
    chk("restart_cnt", cnt_b, 0);
    chk("restart_wrap", wrap_b, 0);
    chk("restart_rstn", rstn_b, 0);
    chk("restart_done", done_b, 0);
    wait_done(1);
    chk("stop_hit", hit_b, 1);
    chk("stop_cnt", cnt_b, 8);
    chk("stop_wrap", wrap_b, 0);
    rd(1, 4'd7, {32'h1C, 32'hA000_001C}, "stop_rd7");
    rd(1, 4'd8, 64'h0, "stop_rd8");
    // stop match disabled
    stop_en = 1'b0;
    push_dump(1);
    pulse(1);
    wait_done(1);
    chk("nostop_hit", hit_b, 0);
    chk("nostop_cnt", cnt_b, 16);
    chk("nostop_wrap", wrap_b, 1);
    // reset mid-RUN at capture 5
    pulse(0);
    for (int n = 0; n < 50 && cnt_a != 5'd4; n++) @(negedge clk);
    chk("reach_cap4", cnt_a, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy_a, 0);
    chk("mid_rstn", rstn_a, 0);
    chk("mid_cnt", cnt_a, 0);
    chk("mid_done", done_a, 0);
    chk("mid_dv", dv_a, 0);
    @(negedge clk);
    // start during HOLD is ignored
    push_dump(0);
    start_a = 1'b1;
    @(negedge clk);
    chk("h2_busy", busy_a, 1);
    chk("h2_rstn1", rstn_a, 0);
    @(negedge clk);
    start_a = 1'b0;
    chk("h2_rstn2", rstn_a, 0);
    @(negedge clk);
    chk("h2_rstn3", rstn_a, 1);
    chk("h2_run", run_a, 1);
    wait_done(0);
    chk("h2_cnt", cnt_a, 10);
    rd(0, 4'd9, {32'h24, 32'hA000_0024}, "h2_rd9");
    repeat (3) @(negedge clk);
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
